alu_req_arbiter: RTL and testbench

Shares one stateful ALU (per-stage ALU with tenant-isolated data RAM) among NUM_REQ requesters, such as per-tenant action lanes. It arbitrates round-robin, issues one action at a time with that requester's page-table entry, and captures the ALU result pulse. It then returns the result to the granted requester over a valid/ready handshake. It sits between the sub_action lanes and the ALU inside one RMT stage.

---
 rtl/alu_req_arbiter_pkg.sv | 15 +
 rtl/alu_req_arbiter_if.sv | 42 ++++
 rtl/alu_req_arbiter_rr_arbiter.sv | 27 ++
 rtl/alu_req_arbiter.sv | 112 +++++++++++
 tb/tb_alu_req_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: shared FSM encoding, page-table field layout and index-width helper
package alu_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam int PTBL_BASE_LSB = 0;
    localparam int PTBL_LEN_LSB = 8;
    localparam int PTBL_FIELD_W = 8;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester-side and ALU-side signals of the shared-ALU arbiter
interface alu_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int PTBL_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ACTION_LEN-1:0] req_action;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op3;
    logic [NUM_REQ*PTBL_WIDTH-1:0] req_ptbl;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic [ACTION_LEN-1:0]         alu_action;
    logic                          alu_action_valid;
    logic [DATA_WIDTH-1:0]         alu_op1;
    logic [DATA_WIDTH-1:0]         alu_op2;
    logic [DATA_WIDTH-1:0]         alu_op3;
    logic [PTBL_WIDTH-1:0]         alu_ptbl;
    logic                          alu_ptbl_valid;
    logic                          alu_ready;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          alu_result_valid;
    logic                          alu_ready_in;
    modport slave (
        input  req_valid, req_action, req_op1, req_op2, req_op3, req_ptbl, rsp_ready,
               alu_ready, alu_result, alu_result_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_action, alu_action_valid,
               alu_op1, alu_op2, alu_op3, alu_ptbl, alu_ptbl_valid, alu_ready_in
    );
    modport master (
        output req_valid, req_action, req_op1, req_op2, req_op3, req_ptbl, rsp_ready,
               alu_ready, alu_result, alu_result_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_action, alu_action_valid,
               alu_op1, alu_op2, alu_op3, alu_ptbl, alu_ptbl_valid, alu_ready_in
    );
endinterface

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// rr_arbiter: rotate requests by the pointer, pick the lowest set bit, rotate the index back
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    localparam logic [IW:0] NW = (IW + 1)'(N);
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_pri;
    logic [IW:0]    w_sum;
    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[N-1:0];
        w_pri = '0;
        for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_pri = (IW + 1)'(k);
        w_sum = w_pri + {1'b0, i_ptr};
        o_idx = IW'(w_sum >= NW ? w_sum - NW : w_sum);
        o_gnt = (|i_req) ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one stateful ALU, one op in flight at a time.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err on expiry.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int PTBL_WIDTH = 16
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input logic clk,
    input logic rst_n,
    alu_req_arbiter_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);
    state_t                r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic [ACTION_LEN-1:0] r_action;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [DATA_WIDTH-1:0] r_op3;
    logic [PTBL_WIDTH-1:0] r_ptbl;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_next_ptr;
    logic                  w_grant;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WDW-1:0]        r_wdog;
    logic                  r_rsp_err;
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif
    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .i_req(bus.req_valid),
        .i_ptr(r_ptr),
        .o_gnt(w_gnt),
        .o_idx(w_idx)
    );
    // rst_n gates the grant so req_ready is also forced low while reset is held
    assign w_grant = rst_n && (r_state == IDLE) && bus.alu_ready && (|w_gnt);
    assign w_next_ptr = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign bus.req_ready = w_grant ? w_gnt : '0;
    assign bus.rsp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_idx) : '0;
    assign bus.rsp_data = r_rsp_data;
    assign bus.alu_action = r_action;
    assign bus.alu_op1 = r_op1;
    assign bus.alu_op2 = r_op2;
    assign bus.alu_op3 = r_op3;
    assign bus.alu_ptbl = r_ptbl;
    assign bus.alu_action_valid = (r_state == ISSUE);
    assign bus.alu_ptbl_valid = (r_state == ISSUE);
    assign bus.alu_ready_in = (r_state == WAIT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_idx <= '0;
            r_action <= '0;
            r_op1 <= '0;
            r_op2 <= '0;
            r_op3 <= '0;
            r_ptbl <= '0;
            r_rsp_data <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_wdog <= '0;
            r_rsp_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_grant) begin
                    r_idx <= w_idx;
                    r_ptr <= w_next_ptr;
                    r_action <= bus.req_action[w_idx*ACTION_LEN +: ACTION_LEN];
                    r_op1 <= bus.req_op1[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_op2 <= bus.req_op2[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_op3 <= bus.req_op3[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_ptbl <= bus.req_ptbl[w_idx*PTBL_WIDTH +: PTBL_WIDTH];
                    r_state <= ISSUE;
                end
                ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    r_wdog <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: if (bus.alu_result_valid) begin
                    r_rsp_data <= bus.alu_result;
`ifdef ALU_ARB_TIMEOUT_EN
                    r_rsp_err <= 1'b0;
`endif
                    r_state <= RESP;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (r_wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
                    r_rsp_data <= '0;
                    r_rsp_err <= 1'b1;
                    r_state <= RESP;
                end else r_wdog <= r_wdog + 1'b1;
`endif
                RESP: if (bus.rsp_ready[r_idx]) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed tests of grant order, latency, backpressure, ALU busy and reset.
// With ALU_ARB_TIMEOUT_EN defined the watchdog path is exercised with TIMEOUT_CYCLES=8.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;
    localparam int N = 4, AL = 25, DW = 32, PW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_auto = 1'b1;
    int checks = 0;
    int failures = 0;
    logic s0, s1;
    logic [DW-1:0] r0, r1;
    logic [AL-1:0] act [N] = '{25'h000_0101, 25'h000_0202, 25'h020_0000, 25'h040_0303};
    logic [DW-1:0] op1 [N] = '{32'd1, 32'd3, 32'd5, 32'd9};
    logic [DW-1:0] op2 [N] = '{32'd2, 32'd4, 32'd7, 32'd11};
    alu_req_arbiter_if #(.NUM_REQ(N), .ACTION_LEN(AL), .DATA_WIDTH(DW), .PTBL_WIDTH(PW)) bus ();
    alu_req_arbiter #(
        .NUM_REQ(N), .ACTION_LEN(AL), .DATA_WIDTH(DW), .PTBL_WIDTH(PW)
`ifdef ALU_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [PW-1:0] ptbl_of(input int i);
        logic [PW-1:0] p;
        p = '0;
        p[PTBL_LEN_LSB +: PTBL_FIELD_W] = 8'(i + 1);
        p[PTBL_BASE_LSB +: PTBL_FIELD_W] = 8'(i * 16);
        return p;
    endfunction
    // Two-cycle ALU model: issue seen in cycle 1, result pulse in cycle 3 = op1 + op2
    initial begin
        s0 = 1'b0; s1 = 1'b0; r0 = '0; r1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s0 = 1'b0; s1 = 1'b0;
                bus.alu_result_valid = 1'b0;
            end else begin
                bus.alu_result_valid = s1;
                bus.alu_result = r1;
                s1 = s0; r1 = r0;
                s0 = alu_auto && bus.alu_action_valid;
                r0 = bus.alu_op1 + bus.alu_op2;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (8) tick();
        bus.rsp_ready = '0;
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0000", bus.rsp_valid); end
        checks++; if ({bus.alu_action_valid, bus.alu_ptbl_valid, bus.alu_ready_in, bus.rsp_err} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0000", {bus.alu_action_valid, bus.alu_ptbl_valid, bus.alu_ready_in, bus.rsp_err}); end
        checks++; if ({bus.rsp_data, bus.alu_action, bus.alu_ptbl} !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.rsp_data, bus.alu_action, bus.alu_ptbl); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    task automatic test_fairness();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        int g = 0, n_iss = 0, last = 0;
        tick();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        for (int c = 0; c < 60 && n_iss < 6; c++) begin
            @(negedge clk);
            if (bus.req_ready != 0 && g < 6) begin
                checks++; if (bus.req_ready !== (4'(1) << exp_seq[g])) begin
                    failures++; $display("FAIL fair_grant%0d got=%b want=%b", g, bus.req_ready, 4'(1) << exp_seq[g]); end
                last = exp_seq[g];
                g++;
            end
            if (bus.alu_action_valid) begin
                checks++; if (bus.alu_ptbl !== ptbl_of(last)) begin
                    failures++; $display("FAIL fair_ptbl lane=%0d got=%h want=%h", last, bus.alu_ptbl, ptbl_of(last)); end
                n_iss++;
            end
            if (bus.rsp_valid != 0) begin
                checks++; if (bus.rsp_valid !== (4'(1) << last) || bus.rsp_data !== op1[last] + op2[last]) begin
                    failures++; $display("FAIL fair_rsp got=%b/%0d want=%b/%0d", bus.rsp_valid, bus.rsp_data, 4'(1) << last, op1[last] + op2[last]); end
            end
        end
        if (n_iss < 6) begin checks++; failures++; $display("FAIL fair_budget issues=%0d want=6", n_iss); end
        drain();
    endtask
    task automatic test_single();
        tick();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b want=0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if ({bus.alu_action_valid, bus.alu_ptbl_valid} !== 2'b11) begin
            failures++; $display("FAIL single_issue got=%b want=11", {bus.alu_action_valid, bus.alu_ptbl_valid}); end
        checks++; if (bus.alu_action !== 25'h020_0000 || bus.alu_op1 !== 32'd5 || bus.alu_op2 !== 32'd7) begin
            failures++; $display("FAIL single_payload got=%h/%0d/%0d want=200000/5/7", bus.alu_action, bus.alu_op1, bus.alu_op2); end
        checks++; if (bus.alu_ptbl !== ptbl_of(2)) begin failures++; $display("FAIL single_ptbl got=%h want=%h", bus.alu_ptbl, ptbl_of(2)); end
        tick();
        @(negedge clk);
        checks++; if ({bus.alu_ready_in, bus.alu_action_valid} !== 2'b10) begin
            failures++; $display("FAIL single_wait got=%b want=10", {bus.alu_ready_in, bus.alu_action_valid}); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL single_early got=%b want=0000", bus.rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd12 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL single_rsp got=%b/%0d/%b want=0100/12/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        tick();
        bus.rsp_ready = 4'b0100;
        tick();
        bus.rsp_ready = '0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL single_done got=%b want=0000", bus.rsp_valid); end
    endtask
    task automatic test_backpressure();
        int c = 0;
        tick();
        bus.req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant got=%b want=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        while (bus.rsp_valid == 0 && c < 10) begin @(negedge clk); c++; end
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'd3) begin
            failures++; $display("FAIL bp_rsp got=%b/%0d want=0001/3", bus.rsp_valid, bus.rsp_data); end
        bus.rsp_ready = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            checks++; if ({bus.rsp_valid, bus.rsp_data, bus.alu_action_valid, bus.req_ready} !== {4'b0001, 32'd3, 1'b0, 4'b0000}) begin
                failures++; $display("FAIL bp_hold%0d got=%b/%0d/%b/%b want=0001/3/0/0000", i, bus.rsp_valid, bus.rsp_data, bus.alu_action_valid, bus.req_ready); end
        end
        tick();
        bus.rsp_ready = 4'b0001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL bp_same_cycle got=%b want=0000", bus.req_ready); end
        tick();
        bus.rsp_ready = '0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b want=0010", bus.req_ready); end
        drain();
    endtask
    task automatic test_alu_busy();
        tick();
        bus.alu_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL busy_hold%0d got=%b want=0000", i, bus.req_ready); end
            tick();
        end
        bus.alu_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL busy_grant got=%b want=0010", bus.req_ready); end
        drain();
    endtask
    task automatic test_reset_mid();
        tick();
        bus.req_valid = 4'hF;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant got=%b want=0100", bus.req_ready); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.alu_ready_in !== 1'b1) begin failures++; $display("FAIL rmid_wait got=%b want=1", bus.alu_ready_in); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.alu_ready_in, bus.alu_action_valid, bus.req_ready, bus.rsp_valid} !== 10'b0) begin
            failures++; $display("FAIL rmid_ctrl got=%b/%b/%b/%b want=0", bus.alu_ready_in, bus.alu_action_valid, bus.req_ready, bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.alu_action, bus.alu_ptbl} !== '0) begin
            failures++; $display("FAIL rmid_data got=%h/%h/%h want=0", bus.rsp_data, bus.alu_action, bus.alu_ptbl); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_regrant got=%b want=0001", bus.req_ready); end
        drain();
    endtask
`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        alu_auto = 1'b0;
        tick();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL to_grant got=%b want=0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        repeat (8) tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0) begin failures++; $display("FAIL to_early got=%b want=0000", bus.rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0) begin
            failures++; $display("FAIL to_rsp got=%b/%b/%0d want=0010/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        alu_auto = 1'b1;
        drain();
    endtask
`endif
    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.alu_ready = 1'b1;
        bus.alu_result = '0;
        bus.alu_result_valid = 1'b0;
        bus.req_op3 = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_action[i*AL +: AL] = act[i];
            bus.req_op1[i*DW +: DW] = op1[i];
            bus.req_op2[i*DW +: DW] = op2[i];
            bus.req_ptbl[i*PW +: PW] = ptbl_of(i);
        end
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_alu_busy();
        test_reset_mid();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
